bcd_multidigit_adder: RTL and testbench

BCD_MULTIDIGIT_ADDER -- requirements
Module: bcd_multidigit_adder

---
 rtl/bcd_multidigit_adder_if.sv | 7 +
 rtl/bcd_multidigit_adder.sv | 69 ++++++
 tb/tb_bcd_multidigit_adder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bcd_multidigit_adder_if.sv
// bcd_multidigit_adder_if: operand/result bundle between a requester and the digit-serial BCD adder
interface bcd_multidigit_adder_if #(parameter int DIGITS = 4);
  logic start, cin, sub, busy, done, cout, err;
  logic [4*DIGITS-1:0] a, b, sum;
  modport master(output start, a, b, cin, sub, input busy, done, sum, cout, err);
  modport slave(input start, a, b, cin, sub, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_multidigit_adder.sv
// bcd_multidigit_adder: digit-serial packed-BCD adder/subtractor, one digit per clock
module bcd_multidigit_adder #(parameter int DIGITS = 4) (
  input logic clk,
  input logic rst,
  bcd_multidigit_adder_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [4:0] LAST = 5'(DIGITS - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, b_q, sum_q;
  logic [4:0] idx_q, t;
  logic [3:0] ad, bd, bp, dig;
  logic sub_q, c_q, done_q, cout_q, err_q, err_in, c_d, accept, last;
  // any operand digit above 9 is flagged at the accepting edge
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) err_in = err_in | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
  end
  // next state plus the single-digit decimal add for the current index
  always_comb begin
    ad = a_q[4*idx_q +: 4];
    bd = b_q[4*idx_q +: 4];
    bp = sub_q ? 4'd9 - bd : bd;
    t = {1'b0, ad} + {1'b0, bp} + {4'b0, c_q};
    c_d = t > 5'd9;
    dig = c_d ? t[3:0] + 4'd6 : t[3:0];
    accept = state_q == IDLE && bus.start;
    last = state_q == BUSY && idx_q == LAST;
    state_d = accept ? BUSY : last ? IDLE : state_q;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // operand latch, digit write-back and completion flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      sub_q <= 1'b0;
      c_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        sub_q <= bus.sub;
        c_q <= bus.cin;
        idx_q <= '0;
        err_q <= err_in;
      end else if (state_q == BUSY) begin
        sum_q[4*idx_q +: 4] <= dig;
        c_q <= c_d;
        idx_q <= idx_q + 5'd1;
        if (last) cout_q <= c_d;
      end
    end
  assign bus.busy = state_q == BUSY;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_multidigit_adder.sv
// tb_bcd_multidigit_adder: vector table, corner sequences and randomized ops against a decimal model
module tb_bcd_multidigit_adder;
  logic clk, rst;
  int pass_cnt = 0, total_cnt = 0;
  bcd_multidigit_adder_if #(.DIGITS(4)) bus();
  bcd_multidigit_adder #(.DIGITS(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [15:0] a, b;
    logic cin, sub;
    logic [15:0] sum;
    logic cout, err;
  } vec_t;
  vec_t tbl [7];
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else pass_cnt++;
  endtask
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
  task automatic do_op(input logic [15:0] a_i, b_i, input logic ci, su,
                       output logic [15:0] s, s_h, output logic co, er, co_h, output int lat);
    @(negedge clk);
    bus.a = a_i;
    bus.b = b_i;
    bus.cin = ci;
    bus.sub = su;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'(1));
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    s = bus.sum;
    co = bus.cout;
    er = bus.err;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(bus.done), 32'(0));
    s_h = bus.sum;
    co_h = bus.cout;
  endtask
  initial begin
    logic [15:0] s, s_h, av, bv, es;
    logic co, er, co_h, ci, su, pos_ok;
    int lat, dc, bc, tot;
    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    tbl[3] = '{16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0};
    tbl[4] = '{16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0};
    tbl[5] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1};
    tbl[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    rst = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_done", 32'(bus.done), 32'(0));
    chk("reset_sum", 32'(bus.sum), 32'(0));
    chk("reset_cout", 32'(bus.cout), 32'(0));
    chk("reset_err", 32'(bus.err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, s, s_h, co, er, co_h, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].cout));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(4));
      chk($sformatf("vec%0d_sum_hold", i), 32'(s_h), 32'(tbl[i].sum));
      chk($sformatf("vec%0d_cout_hold", i), 32'(co_h), 32'(tbl[i].cout));
    end
    @(negedge clk);
    bus.a = 16'h0011;
    bus.b = 16'h0022;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    dc = 0;
    bc = 0;
    pos_ok = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dc++;
        if (e % 5 != 0) pos_ok = 1'b0;
      end
      if (bus.busy) bc++;
    end
    bus.start = 1'b0;
    chk("held_start_done_count", 32'(dc), 32'(3));
    chk("held_start_busy_cycles", 32'(bc), 32'(12));
    chk("held_start_done_spacing", 32'(pos_ok), 32'(1));
    chk("held_start_sum", 32'(bus.sum), 32'(16'h0033));
    @(negedge clk);
    bus.a = 16'h43A1;
    bus.b = 16'h1111;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("pre_reset_err", 32'(bus.err), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_reset_busy", 32'(bus.busy), 32'(0));
    chk("midop_reset_done", 32'(bus.done), 32'(0));
    chk("midop_reset_sum", 32'(bus.sum), 32'(0));
    chk("midop_reset_cout", 32'(bus.cout), 32'(0));
    chk("midop_reset_err", 32'(bus.err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) dc++;
    end
    chk("midop_reset_no_done", 32'(dc), 32'(0));
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, s_h, co, er, co_h, lat);
    chk("after_reset_sum", 32'(s), 32'(16'h0002));
    chk("after_reset_latency", 32'(lat), 32'(4));
    for (int r = 0; r < 20; r++) begin
      av = int2bcd(int'($urandom_range(0, 9999)));
      bv = int2bcd(int'($urandom_range(0, 9999)));
      ci = 1'($urandom);
      su = 1'($urandom);
      tot = bcd2int(av) + (su ? 9999 - bcd2int(bv) : bcd2int(bv)) + int'(ci);
      es = int2bcd(tot % 10000);
      do_op(av, bv, ci, su, s, s_h, co, er, co_h, lat);
      chk($sformatf("rand%0d_sum", r), 32'(s), 32'(es));
      chk($sformatf("rand%0d_cout", r), 32'(co), 32'(tot >= 10000));
      chk($sformatf("rand%0d_err", r), 32'(er), 32'(0));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
